// File: rtl/serializador_paralelo_serial.sv
// serializador_paralelo_serial: parallel-to-serial stage with a one-word holding register
// for gapless streaming of WIDTH-bit words, one bit per clock on out.
module serializador_paralelo_serial #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] hold, hold_nx, shreg, shreg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic hold_full, hold_full_nx, accept, load, word_end;
    // data_ready depends on registered hold_full only, so accept and load never coincide
    assign data_ready = !hold_full && !reset;
    assign accept     = data_valid && data_ready;
    assign word_end   = state == SHIFT && cnt == CW'(WIDTH - 1);
    assign load       = hold_full && (state == IDLE || word_end);
    assign out_valid  = state == SHIFT;
    assign out_last   = word_end;
    assign out        = out_valid && (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    assign busy       = out_valid || hold_full;
    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        cnt_nx       = cnt;
        hold_nx      = accept ? data_in : hold;
        hold_full_nx = accept ? 1'b1 : load ? 1'b0 : hold_full;
        if (load) begin
            state_nx = SHIFT;
            shreg_nx = hold;
            cnt_nx   = '0;
        end else if (word_end) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == SHIFT) begin
            shreg_nx = LSB_FIRST ? shreg >> 1 : shreg << 1;
            cnt_nx   = cnt + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
        end
    end
endmodule

// File: tb/tb_serializador_paralelo_serial.sv
// tb_serializador_paralelo_serial: random and directed stimulus on an MSB-first and an
// LSB-first instance, checked every cycle against a queue-based word/bit model.
module tb_serializador_paralelo_serial;
    localparam int W = 8;
    logic clock = 1'b0, reset = 1'b1, data_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic r0, o0, v0, l0, b0, r1, o1, v1, l1, b1;
    int checks = 0, errors = 0, cap_n = 0;
    logic [15:0] cap = '0;
    bit q0[$], q1[$];
    bit m_full = 1'b0;
    logic [W-1:0] m_hold = '0;

    serializador_paralelo_serial #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(r0), .out(o0), .out_valid(v0), .out_last(l0), .busy(b0));
    serializador_paralelo_serial #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(r1), .out(o1), .out_valid(v1), .out_last(l1), .busy(b1));

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        check_val("ready0", r0, !m_full && !reset);
        check_val("ready1", r1, !m_full && !reset);
        check_val("valid0", v0, q0.size() > 0);
        check_val("valid1", v1, q1.size() > 0);
        check_val("out0", o0, q0.size() > 0 ? q0[0] : 1'b0);
        check_val("out1", o1, q1.size() > 0 ? q1[0] : 1'b0);
        check_val("last0", l0, q0.size() == 1);
        check_val("last1", l1, q1.size() == 1);
        check_val("busy0", b0, q0.size() > 0 || m_full);
        check_val("busy1", b1, q1.size() > 0 || m_full);
    endtask

    // model step at a posedge: finish current bit, refill the bit queues from hold, then accept
    task automatic model_edge();
        bit acc;
        if (reset) begin
            q0.delete();
            q1.delete();
            m_full = 1'b0;
        end else begin
            acc = data_valid && !m_full;
            if (q0.size() > 0) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (q0.size() == 0 && m_full) begin
                for (int i = W - 1; i >= 0; i--) q0.push_back(m_hold[i]);
                for (int i = 0; i < W; i++) q1.push_back(m_hold[i]);
                m_full = 1'b0;
            end
            if (acc) begin
                m_hold = data_in;
                m_full = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [W-1:0] d);
        @(negedge clock);
        compare();
        if (v0) begin
            cap = {cap[14:0], o0};
            cap_n++;
        end
        reset = rst;
        data_valid = v;
        data_in = d;
        @(posedge clock);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic [W-1:0] w);
        bit a;
        int tries = 0;
        do begin
            a = !m_full;
            step(1'b0, 1'b1, w);
            tries++;
        end while (!a && tries < W + 4);
        if (!a) check_val("send_timeout", tries, 0);
    endtask

    initial begin
        bit pend = 1'b0, r, v, a;
        logic [W-1:0] d = '0;
        @(posedge clock);
        model_edge();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(3);
        cap_n = 0;
        send(8'hA5);
        idle(10);
        check_val("a5_bits", cap[7:0], 8'hA5);
        check_val("a5_count", cap_n, 8);
        cap_n = 0;
        send(8'h0A);
        send(8'hF0);
        idle(20);
        check_val("stream_bits", cap, 16'h0AF0);
        check_val("stream_count", cap_n, 16);
        send(8'h01);
        idle(10);
        send(8'hFF);
        send(8'h55);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        cap_n = 0;
        idle(12);
        check_val("no_55", cap_n, 0);
        send(8'hAA);
        idle(10);
        check_val("aa_bits", cap[7:0], 8'hAA);
        for (int i = 0; i < 3000; i++) begin
            if (!pend) d = W'($urandom);
            r = $urandom_range(0, 199) == 0;
            v = pend || ($urandom_range(0, 9) < 7);
            a = v && !m_full && !r;
            step(r, v, d);
            pend = v && !a && !r;
        end
        idle(12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
